// File: rtl/shift_pkg.sv
// shift_pkg: shared definitions for the serial SRL scheduler.
//   FUNCT_SRL   - function code that selects a logical right shift
//   WIDTH_DEF   - default data width
//   SHW_DEF     - default shift-amount width (also the number of stages)
//   state_t     - scheduler FSM state encoding
package shift_pkg;

    localparam int          WIDTH_DEF = 32;
    localparam int          SHW_DEF   = 5;
    localparam logic [5:0]  FUNCT_SRL = 6'b000010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_stage.sv
// shift_stage: one log2 stage of a logical right shifter, shared by every
// pass of the serial sequencer.
//   din  - operand
//   en   - apply this stage (the shift-amount bit for stage k)
//   k    - stage index; the stage shifts by 2**k
//   dout - din >> 2**k when en, else din (zero fill from the MSB)
module shift_stage #(
    parameter int WIDTH = 32,
    parameter int KW    = 3
) (
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] dout
);

    assign dout = en ? (din >> (32'd1 << k)) : din;

endmodule

// File: rtl/shift_sched.sv
// shift_sched: two-port round-robin scheduler for a serial 32-bit SRL.
// A granted request is captured, shifted one log2 stage per cycle through a
// single shift_stage, and returned on the response port with its port ID.
// Non-SRL function codes bypass the shifter and return the operand with err.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A request holds valid and its payload until it sees ready; the
// scheduler only raises reqN_ready in IDLE for the granted port. rsp_valid
// stays high with rsp_data/rsp_id/rsp_err stable until rsp_ready is seen.
//
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   reqN_valid/ready      - request handshake, N = 0, 1
//   reqN_data/shamt/funct - operand, shift amount, function code
//   rsp_valid/ready       - response handshake
//   rsp_data/id/err       - result, requester ID, non-SRL flag
//   busy                  - a transaction is in flight (state != IDLE)
//   dbg_state             - current FSM state
module shift_sched
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = SHW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [SHW-1:0]   req0_shamt,
    input  logic [5:0]       req0_funct,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [SHW-1:0]   req1_shamt,
    input  logic [5:0]       req1_funct,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    output logic             rsp_err,
    output logic             busy,
    output state_t           dbg_state
);

    localparam int          KW     = (SHW > 1) ? $clog2(SHW) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(SHW - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   shamt_r;
    logic [KW-1:0]    k;
    logic             id_r;
    logic             err_r;
    logic             last_grant;   // 1: port 1 was granted last, so port 0 wins a tie

    logic             grant0;
    logic             grant1;
    logic             hs;
    logic [WIDTH-1:0] sel_data;
    logic [SHW-1:0]   sel_shamt;
    logic [5:0]       sel_funct;
    logic [WIDTH-1:0] stage_out;

    // Round-robin arbitration between the two requesters.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_grant);
        grant1 = req1_valid & (~req0_valid | ~last_grant);
    end

    assign hs        = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign sel_data  = grant1 ? req1_data  : req0_data;
    assign sel_shamt = grant1 ? req1_shamt : req0_shamt;
    assign sel_funct = grant1 ? req1_funct : req0_funct;

    shift_stage #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_stage (
        .din  (acc),
        .en   (shamt_r[k]),
        .k    (k),
        .dout (stage_out)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (hs) begin
                    state_nxt = (sel_funct == FUNCT_SRL) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (k == K_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic. Ready is also held low while reset is asserted so nothing
    // looks accepted during reset.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                req0_ready = grant0 & reset;
                req1_ready = grant1 & reset;
                busy       = 1'b0;
            end
            DONE:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign rsp_data  = acc;
    assign rsp_id    = id_r;
    assign rsp_err   = err_r;
    assign dbg_state = state;

    // Datapath and arbitration registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc        <= '0;
            shamt_r    <= '0;
            k          <= '0;
            id_r       <= 1'b0;
            err_r      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        acc        <= sel_data;
                        shamt_r    <= sel_shamt;
                        id_r       <= grant1;
                        err_r      <= (sel_funct != FUNCT_SRL);
                        k          <= '0;
                        last_grant <= grant1;
                    end
                end
                SHIFT: begin
                    // Every stage runs, even when the shift-amount bit is 0,
                    // to keep latency fixed.
                    acc <= stage_out;
                    k   <= (k == K_LAST) ? '0 : k + KW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sched.sv
// tb_shift_sched: directed self-checking bench for shift_sched.
module tb_shift_sched;
    import shift_pkg::*;

    localparam int W = 32;
    localparam int S = 5;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_data, req1_data;
    logic [S-1:0] req0_shamt, req1_shamt;
    logic [5:0]   req0_funct, req1_funct;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [W-1:0] rsp_data;
    state_t       dbg_state;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int lat;
    int rdy_seen;
    int bad;

    always #5 clk = ~clk;

    shift_sched #(.WIDTH(W), .SHW(S)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_shamt (req0_shamt),
        .req0_funct (req0_funct),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_shamt (req1_shamt),
        .req1_funct (req1_funct),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic drive(input int port, input logic [W-1:0] d, input logic [S-1:0] sh,
                         input logic [5:0] f);
        if (port == 0) begin
            req0_data = d; req0_shamt = sh; req0_funct = f; req0_valid = 1'b1;
        end else begin
            req1_data = d; req1_shamt = sh; req1_funct = f; req1_valid = 1'b1;
        end
    endtask

    // Counts negedges after the accept edge until rsp_valid, bounded.
    task automatic wait_rsp(output int l, output int rs);
        l  = 0;
        rs = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            l++;
            if (req0_ready || req1_ready) rs++;
            if (rsp_valid) break;
        end
    endtask

    task automatic rsp_take();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    // Single-port SRL/error transaction with full result check.
    task automatic run_one(input string tag, input int port, input logic [W-1:0] d,
                           input logic [S-1:0] sh, input logic [5:0] f,
                           input logic [W-1:0] exp_d, input int exp_lat, input logic exp_err);
        @(negedge clk);
        drive(port, d, sh, f);
        #1;
        chk({tag, "_ready"}, (port == 0) ? req0_ready : req1_ready, 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(lat, rdy_seen);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_data"}, rsp_data, exp_d);
        chk({tag, "_id"}, rsp_id, port[0]);
        chk({tag, "_err"}, rsp_err, exp_err);
        rsp_take();
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_data = 0; req1_data = 0; req0_shamt = 0; req1_shamt = 0;
        req0_funct = 0; req1_funct = 0;

        // Reset values, with a request pending to show ready stays low.
        req0_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        req0_valid = 1'b0;
        reset = 1'b1;

        // Full-width shift of the MSB.
        run_one("msb31", 0, 32'h8000_0000, 5'd31, FUNCT_SRL, 32'h0000_0001, 6, 1'b0);

        // Tie after reset: req0 first, req1 held off while busy.
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        drive(0, 32'hFFFF_FFFF, 5'd4, FUNCT_SRL);
        drive(1, 32'h1234_5678, 5'd8, FUNCT_SRL);
        #1;
        chk("tie_ready0", req0_ready, 1);
        chk("tie_ready1", req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        chk("tie_busy", busy, 1);
        wait_rsp(lat, rdy_seen);
        chk("tie0_lat", lat, 6);
        chk("tie0_noaccept", rdy_seen, 0);
        chk("tie0_data", rsp_data, 32'h0FFF_FFFF);
        chk("tie0_id", rsp_id, 0);
        rsp_take();
        chk("tie1_ready", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_rsp(lat, rdy_seen);
        chk("tie1_lat", lat, 6);
        chk("tie1_data", rsp_data, 32'h0012_3456);
        chk("tie1_id", rsp_id, 1);
        chk("tie1_err", rsp_err, 0);
        rsp_take();

        // Non-SRL function code bypasses the shifter.
        run_one("err", 1, 32'hDEAD_BEEF, 5'd3, 6'b000000, 32'hDEAD_BEEF, 1, 1'b1);

        // Response stall: outputs hold and nothing is accepted.
        @(negedge clk);
        drive(0, 32'h0000_F000, 5'd12, FUNCT_SRL);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_rsp(lat, rdy_seen);
        chk("stall_lat", lat, 6);
        chk("stall_data", rsp_data, 32'h0000_000F);
        drive(1, 32'h0000_0010, 5'd1, FUNCT_SRL);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== 32'h0000_000F || rsp_id !== 1'b0 ||
                rsp_err !== 1'b0 || req0_ready || req1_ready) bad++;
        end
        chk("stall_hold", bad, 0);
        rsp_take();
        chk("stall_rel_busy", busy, 0);
        chk("stall_rel_valid", rsp_valid, 0);
        chk("stall_rel_ready1", req1_ready, 1);
        req1_valid = 1'b0;

        // Reset in the middle of SHIFT (k == 2).
        @(negedge clk);
        drive(0, 32'h0000_0100, 5'd8, FUNCT_SRL);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("mid_state", 32'(dbg_state), 32'(SHIFT));
        reset = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_valid", rsp_valid, 0);
        chk("mid_data", rsp_data, 0);
        chk("mid_id", rsp_id, 0);
        chk("mid_err", rsp_err, 0);
        chk("mid_state_idle", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        reset = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) bad++;
        end
        chk("mid_no_rsp", bad, 0);
        drive(0, 32'h0000_0100, 5'd8, FUNCT_SRL);
        drive(1, 32'h0000_0200, 5'd1, FUNCT_SRL);
        #1;
        chk("mid_tie_ready0", req0_ready, 1);
        chk("mid_tie_ready1", req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(lat, rdy_seen);
        chk("mid_lat", lat, 6);
        chk("mid_rdata", rsp_data, 32'h0000_0001);
        chk("mid_rid", rsp_id, 0);
        rsp_take();

        // Zero shift still takes the full latency; a few more patterns.
        run_one("zero", 1, 32'hA5A5_A5A5, 5'd0, FUNCT_SRL, 32'hA5A5_A5A5, 6, 1'b0);
        run_one("sh17", 0, 32'hFFFF_0000, 5'd17, FUNCT_SRL, 32'h0000_7FFF, 6, 1'b0);
        run_one("sh31", 1, 32'h1234_5678, 5'd31, FUNCT_SRL, 32'h0000_0000, 6, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed",
                 pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule

// File: doc/shift_sched.md
# shift_sched

Two-port round-robin scheduler and sequencer for the ALU's 32-bit logical right shift (SRL). It accepts shift requests from two requesters over valid/ready handshakes and performs each shift serially, one log2 stage per cycle, through a single shared stage. It returns the result on a valid/ready response port tagged with the requester ID. It sits between the ALU control and the writeback mux, replacing a five-stage combinational shifter where area matters more than latency.

## Interface
- WIDTH, 32: data width.
- SHW, 5: shift-amount width; stage count = SHW.
- clk  in  1: sole clock, rising edge.
- reset  in  1: asynchronous, active-low reset.
- req0_valid / req1_valid  in  1: request present.
- req0_ready / req1_ready  out  1: request accepted this cycle.
- req0_data / req1_data  in  WIDTH: operand.
- req0_shamt / req1_shamt  in  SHW: shift amount.
- req0_funct / req1_funct  in  6: function code; SRL = 6'b000010.
- rsp_valid  out  1: result available.
- rsp_ready  in  1: consumer takes result.
- rsp_data  out  WIDTH: result.
- rsp_id  out  1: requester ID (0 or 1).
- rsp_err  out  1: funct was not SRL.
- busy  out  1: state != IDLE.

## Operation
- FSM with three states: IDLE, SHIFT, DONE.
- IDLE:
  - Round-robin grant. If only one valid, grant it. If both valid, grant the port not granted last.
  - reqN_ready = (state==IDLE) & grantN, combinational.
  - On handshake, capture data into acc, and capture shamt, funct, and id.
  - Stage counter k resets to 0. The last-grant pointer updates.
  - funct==SRL goes to SHIFT. Any other funct goes to DONE with err=1 and acc unchanged.
- SHIFT:
  - Each cycle: acc <= shamt[k] ? acc >> (1<<k) : acc, zero-filled from the MSB.
  - k increments. After k==SHW-1, go to DONE.
  - All SHW stages always run (fixed latency), including shamt==0.
- DONE:
  - rsp_valid=1. rsp_data/id/err are driven from registers and held stable while rsp_ready=0.
  - On rsp_valid & rsp_ready, go to IDLE.
  - Both reqN_ready are 0 in DONE and SHIFT; no acceptance occurs in the response-handshake cycle.
- Width rules: the shift amount is unsigned 0..2^SHW-1. Bits shifted past bit 0 are discarded. Shift 31 of 0x80000000 yields 0x00000001.
- Reset (asynchronous, any state):
  - state=IDLE, acc=0, k=0, id=0, err=0.
  - The last-grant pointer is set so req0 wins the next tie.
  - Any in-flight transaction is dropped with no response.

## Timing
- Reset values: req0_ready=0, req1_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, busy=0. While in IDLE after reset, reqN_ready follows the grant logic.
- SRL latency: handshake at edge E; SHIFT occupies cycles E+1..E+SHW; rsp_valid is high from E+SHW+1 (6 cycles for SHW=5).
- Error latency: rsp_valid is high from E+1.
- Minimum interval between accepts: SHW+2 cycles (SRL), 2 cycles (error).
- busy goes high the cycle after accept and low the cycle after the response handshake.

## Structure
- Package shift_pkg holds:
  - FUNCT_SRL = 6'b000010.
  - State enum {IDLE, SHIFT, DONE}.
  - Default WIDTH/SHW constants.
- Sub-module shift_stage (combinational): out = en ? in >> (1<<k) : in, with k selecting the stage. This is the single shared datapath stage. The FSM, arbiter, and registers stay in shift_sched.

## Test plan
- req0 data=0x80000000, shamt=31, SRL → rsp_data=0x00000001, id=0, err=0; rsp_valid exactly 6 cycles after accept.
- After reset, req0 (0xFFFFFFFF, shamt=4) and req1 (0x12345678, shamt=8) valid together → first response id=0, data=0x0FFFFFFF; second response id=1, data=0x00123456; no request accepted while busy.
- req1 funct=6'b000000, data=0xDEADBEEF → rsp_err=1, rsp_data=0xDEADBEEF, rsp_valid 1 cycle after accept.
- rsp_ready held low 10 cycles in DONE → rsp_valid/data/id stable and both reqN_ready=0; release → IDLE next cycle.
- reset asserted in SHIFT at k=2 → all outputs 0 immediately with no response emitted; after release, req0 wins a tie.
- shamt=0, data=0xA5A5A5A5 → rsp_data=0xA5A5A5A5 after the full 6-cycle latency.
